// File: rtl/mux_pkg.sv
// Shared TDM encodings: slot numbering, receiver FSM states and the error
// counter ceiling. A future TDM transmitter is expected to reuse these.
package mux_pkg;
  localparam logic [1:0] SLOT_A = 2'b00;
  localparam logic [1:0] SLOT_B = 2'b01;
  localparam logic [1:0] SLOT_C = 2'b10;
  localparam logic [1:0] SLOT_D = 2'b11;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;
endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit TDM slot counter. Clear beats load-to-1, which beats increment.
module tdm_slot_ctr
  import mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load1,
  input  logic       clr,
  output logic [1:0] slot
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     slot <= SLOT_A;
    else if (clr)   slot <= SLOT_A;
    else if (load1) slot <= SLOT_B;
    else if (inc)   slot <= slot + 2'd1;
  end
endmodule

// File: rtl/demux1to4_tdm.sv
// 1:4 TDM receiver. Aligns a slot counter to SYNC, stages slots 0..2 and
// publishes a whole frame on A..D when slot 3 arrives.
module demux1to4_tdm
  import mux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic         SYNC,
  input  logic [W-1:0] DIN,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         S1,
  output logic         S0,
  output logic         FRAME_VALID,
  output logic         LOCK,
  output logic         ERR,
  output logic [7:0]   ERR_CNT
);
  tdm_state_t          state_q, state_d;
  logic [1:0]          slot;
  logic [2:0][W-1:0]   stg_q;
  logic [3:0][W-1:0]   out_q;
  logic [2:0]          stg_we;
  logic                frame_upd, viol, ctr_inc, ctr_ld, ctr_clr;
  logic                fv_q, err_q;
  logic [7:0]          err_cnt_q;

  tdm_slot_ctr u_slot_ctr (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (ctr_inc),
    .load1 (ctr_ld),
    .clr   (ctr_clr),
    .slot  (slot)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  // A SYNC always restarts the frame at slot 0; it is only a violation
  // when it lands mid-frame while locked.
  always_comb begin
    state_d   = state_q;
    stg_we    = '0;
    frame_upd = 1'b0;
    viol      = 1'b0;
    ctr_inc   = 1'b0;
    ctr_ld    = 1'b0;
    ctr_clr   = 1'b0;
    if (EN) begin
      unique case (state_q)
        ST_HUNT: begin
          if (SYNC) begin
            stg_we[0] = 1'b1;
            ctr_ld    = 1'b1;
            state_d   = ST_LOCKED;
          end else begin
            ctr_clr   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (SYNC) begin
            stg_we[0] = 1'b1;
            ctr_ld    = 1'b1;
            viol      = (slot != SLOT_A);
          end else if (slot == SLOT_A) begin
            viol      = 1'b1;
            ctr_clr   = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            ctr_inc   = 1'b1;
            stg_we[1] = (slot == SLOT_B);
            stg_we[2] = (slot == SLOT_C);
            frame_upd = (slot == SLOT_D);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stg_q     <= '0;
      out_q     <= '0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (stg_we[i]) stg_q[i] <= DIN;
      if (frame_upd) out_q <= {DIN, stg_q[2], stg_q[1], stg_q[0]};
      fv_q  <= frame_upd;
      err_q <= viol;
      if (viol && err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign A           = out_q[0];
  assign B           = out_q[1];
  assign C           = out_q[2];
  assign D           = out_q[3];
  assign {S1, S0}    = slot;
  assign FRAME_VALID = fv_q;
  assign LOCK        = (state_q == ST_LOCKED);
  assign ERR         = err_q;
  assign ERR_CNT     = err_cnt_q;
endmodule

// File: tb/tb_demux1to4_tdm.sv
// Scoreboard bench for demux1to4_tdm at W=8: expected frames are queued as
// words are driven and popped whenever FRAME_VALID is seen.
module tb_demux1to4_tdm;
  localparam int W = 8;

  logic         clk, rst_n, en, sync;
  logic [W-1:0] din, a, b, c, d;
  logic         s1, s0, fv, lock, err;
  logic [7:0]   err_cnt;

  int           n_vec, n_err, fv_seen, exp_cnt;
  logic [31:0]  exp_q[$];

  demux1to4_tdm #(.W(W)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SYNC(sync), .DIN(din),
    .A(a), .B(b), .C(c), .D(d), .S1(s1), .S0(s0),
    .FRAME_VALID(fv), .LOCK(lock), .ERR(err), .ERR_CNT(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are read #1 after
  // the rising edge that consumed them.
  task automatic step(input logic en_i, input logic sync_i, input logic [W-1:0] din_i);
    @(negedge clk);
    en = en_i; sync = sync_i; din = din_i;
    @(posedge clk);
    #1;
  endtask

  task automatic gap3();
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'($urandom), W'($urandom));
      chk("gap_fv", 32'(fv), 32'd0);
    end
  endtask

  task automatic bump_err();
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
  endtask

  always @(negedge clk) begin
    if (rst_n && fv) begin
      fv_seen++;
      if (exp_q.size() == 0) chk("unexpected_fv", 32'd1, 32'd0);
      else chk("frame", {a, b, c, d}, exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fa, fb, fc, fd;
    int           fv0;
    n_vec = 0; n_err = 0; fv_seen = 0; exp_cnt = 0;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = '0;

    // reset and hunting without SYNC
    repeat (3) @(negedge clk);
    #1;
    chk("rst_abcd", {a, b, c, d}, 32'd0);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_slot", 32'({s1, s0}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      chk("hunt_lock", 32'(lock), 32'd0);
    end
    chk("hunt_fv_none", 32'(fv_seen), 32'd0);

    // lock and first frame
    exp_q.push_back({8'd1, 8'd0, 8'd1, 8'd0});
    step(1'b1, 1'b1, 8'd1);
    chk("lock_up", 32'(lock), 32'd1);
    chk("slot_after_sync", 32'({s1, s0}), 32'd1);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd1);
    chk("fv_early", 32'(fv), 32'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("fv_frame1", 32'(fv), 32'd1);
    chk("slot_wrap", 32'({s1, s0}), 32'd0);
    step(1'b0, 1'b0, 8'd0);
    chk("fv_one_cycle", 32'(fv), 32'd0);

    // gapped frame
    fv0 = fv_seen;
    exp_q.push_back({8'd1, 8'd0, 8'd1, 8'd0});
    step(1'b1, 1'b1, 8'd1); gap3();
    step(1'b1, 1'b0, 8'd0); gap3();
    step(1'b1, 1'b0, 8'd1); gap3();
    chk("gap_no_fv_yet", 32'(fv_seen - fv0), 32'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("gap_fv_4th", 32'(fv), 32'd1);

    // early sync realigns without publishing the partial frame
    fv0 = fv_seen + 1;
    step(1'b1, 1'b1, 8'd1);
    step(1'b1, 1'b0, 8'd1);
    exp_q.push_back({8'd0, 8'd0, 8'd0, 8'd1});
    step(1'b1, 1'b1, 8'd0);
    bump_err();
    chk("early_err", 32'(err), 32'd1);
    chk("early_cnt", 32'(err_cnt), 32'(exp_cnt));
    chk("early_lock", 32'(lock), 32'd1);
    chk("early_slot", 32'({s1, s0}), 32'd1);
    chk("early_abcd_held", {a, b, c, d}, {8'd1, 8'd0, 8'd1, 8'd0});
    step(1'b1, 1'b0, 8'd0);
    chk("early_err_pulse", 32'(err), 32'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd1);
    chk("early_fv_count", 32'(fv_seen + (fv ? 0 : 1)), 32'(fv0));
    chk("early_next_fv", 32'(fv), 32'd1);

    // missing sync at slot 0 drops lock and holds outputs
    step(1'b1, 1'b0, 8'hEE);
    bump_err();
    chk("miss_err", 32'(err), 32'd1);
    chk("miss_lock", 32'(lock), 32'd0);
    chk("miss_cnt", 32'(err_cnt), 32'(exp_cnt));
    chk("miss_abcd_held", {a, b, c, d}, {8'd0, 8'd0, 8'd0, 8'd1});

    // drive the counter into saturation, relocking between violations
    for (int i = 0; i < 299; i++) begin
      fa = W'($urandom); fb = W'($urandom); fc = W'($urandom); fd = W'($urandom);
      exp_q.push_back({fa, fb, fc, fd});
      step(1'b1, 1'b1, fa);
      step(1'b1, 1'b0, fb);
      step(1'b1, 1'b0, fc);
      step(1'b1, 1'b0, fd);
      chk("sat_fv", 32'(fv), 32'd1);
      step(1'b1, 1'b0, W'($urandom));
      bump_err();
      chk("sat_err", 32'(err), 32'd1);
      chk("sat_cnt", 32'(err_cnt), 32'(exp_cnt));
      chk("sat_held", {a, b, c, d}, {fa, fb, fc, fd});
    end
    chk("sat_final", 32'(err_cnt), 32'd255);

    // asynchronous reset after slot 2
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_abcd", {a, b, c, d}, 32'd0);
    chk("arst_lock", 32'(lock), 32'd0);
    chk("arst_cnt", 32'(err_cnt), 32'd0);
    chk("arst_slot", 32'({s1, s0}), 32'd0);
    chk("arst_pulses", 32'({fv, err}), 32'd0);
    exp_cnt = 0;
    step(1'b1, 1'b0, 8'h44);
    chk("arst_held_lock", 32'(lock), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    exp_q.push_back({8'hA5, 8'h3C, 8'hFF, 8'h00});
    step(1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 8'h00);
    chk("fresh_fv", 32'(fv), 32'd1);
    chk("fresh_cnt", 32'(err_cnt), 32'd0);
    step(1'b0, 1'b0, 8'h00);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
